branch_resolve_unit: RTL and testbench

//  Consumer side of the integer comparators: takes a decoded branch/jump plus

---
 rtl/branch_resolve_unit.sv | 258 +++++++++++++++++++++++++
 tb/tb_branch_resolve_unit.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_unit.sv
`default_nettype none
// ============================================================================
// Module   : branch_resolve_unit
// Purpose  : Resolves one decoded RV32I branch or jump at a time.
//            - Evaluates the condition (EQ/NE/LT/GE/LTU/GEU).
//            - Computes the target address.
//            - Holds a redirect/flush request toward fetch until fetch
//              accepts it.
//            Sits between decode and the PC mux.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Parameters
//   XLEN  operand width (rs1/rs2/imm), default 32
//   PC_W  program-counter width, default 32 (PC_W <= XLEN)
// Ports
//   i_clk          in   1     clock, rising edge
//   i_rst          in   1     asynchronous active-high reset
//   i_valid        in   1     decode presents a branch/jump
//   o_ready        out  1     unit can accept (IDLE only)
//   i_funct3       in   3     branch condition select
//   i_is_jal       in   1     unconditional PC-relative jump
//   i_is_jalr      in   1     unconditional register jump (wins over jal)
//   i_rs1, i_rs2   in   XLEN  operands
//   i_imm          in   XLEN  sign-extended immediate
//   i_pc           in   PC_W  instruction PC
//   o_res_valid    out  1     one-cycle result strobe
//   o_taken        out  1     resolved direction
//   o_link         out  PC_W  pc+4
//   o_illegal      out  1     reserved funct3 on a conditional branch
//   o_misaligned   out  1     taken target with bit[1] set
//   o_redir_valid  out  1     redirect request to fetch
//   i_redir_ready  in   1     fetch accepts redirect
//   o_redir_pc     out  PC_W  redirect address, held while o_redir_valid
//   o_flush        out  1     pulse on the redirect handshake
// Build option
//   BRU_STATIC_PRED_EN
//     Fetch is assumed to have predicted two cases as taken:
//       - backward conditional branches
//       - jal
//     A redirect is raised only when that prediction was wrong.
//     Without this macro, every taken branch or jump redirects.
// ============================================================================
module branch_resolve_unit #(
  parameter int XLEN = 32,
  parameter int PC_W = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [2:0]      i_funct3,
  input  logic            i_is_jal,
  input  logic            i_is_jalr,
  input  logic [XLEN-1:0] i_rs1,
  input  logic [XLEN-1:0] i_rs2,
  input  logic [XLEN-1:0] i_imm,
  input  logic [PC_W-1:0] i_pc,
  output logic            o_res_valid,
  output logic            o_taken,
  output logic [PC_W-1:0] o_link,
  output logic            o_illegal,
  output logic            o_misaligned,
  output logic            o_redir_valid,
  input  logic            i_redir_ready,
  output logic [PC_W-1:0] o_redir_pc,
  output logic            o_flush
);

  localparam logic [PC_W-1:0] C_FOUR     = PC_W'(4);
  localparam logic [PC_W-1:0] C_CLR_BIT0 = ~PC_W'(1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_EVAL     = 2'd1,
    S_REDIRECT = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // captured instruction
  logic [2:0]      r_funct3;
  logic            r_is_jal;
  logic            r_is_jalr;
  logic [XLEN-1:0] r_rs1;
  logic [XLEN-1:0] r_rs2;
  logic [XLEN-1:0] r_imm;
  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] r_redir_pc;

  logic            w_is_cond;
  logic            w_illegal;
  logic            w_eq;
  logic            w_signed_lt;
  logic            w_unsigned_lt;
  logic            w_cond_true;
  logic            w_taken;
  logic            w_misaligned;
  logic            w_pred_taken;
  logic            w_need_redir;
  logic [PC_W-1:0] w_branch_tgt;
  logic [XLEN-1:0] w_jalr_sum;
  logic [PC_W-1:0] w_jalr_tgt;
  logic [PC_W-1:0] w_target;
  logic [PC_W-1:0] w_link;
  logic [PC_W-1:0] w_redir_tgt;

  // --------------------------------------------------------------------------
  // State register and operand capture
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_funct3   <= '0;
      r_is_jal   <= 1'b0;
      r_is_jalr  <= 1'b0;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_imm      <= '0;
      r_pc       <= '0;
      r_redir_pc <= '0;
    end else begin
      if (r_state == S_IDLE && i_valid) begin
        r_funct3  <= i_funct3;
        r_is_jal  <= i_is_jal;
        r_is_jalr <= i_is_jalr;
        r_rs1     <= i_rs1;
        r_rs2     <= i_rs2;
        r_imm     <= i_imm;
        r_pc      <= i_pc;
      end
      // Latched once so the address stays stable for the whole request.
      if (r_state == S_EVAL) begin
        r_redir_pc <= w_redir_tgt;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Condition evaluation
  // --------------------------------------------------------------------------
  assign w_is_cond     = ~r_is_jal & ~r_is_jalr;
  assign w_illegal     = w_is_cond & (r_funct3[2:1] == 2'b01);
  assign w_eq          = (r_rs1 == r_rs2);
  assign w_unsigned_lt = (r_rs1 < r_rs2);

  // Signed compare: when the signs differ, the negative operand is smaller.
  // When the signs match, the lower bits order the operands the same way
  // they would if compared as unsigned values.
  assign w_signed_lt = (r_rs1[XLEN-1] != r_rs2[XLEN-1]) ? r_rs1[XLEN-1]
                     : (r_rs1[XLEN-2:0] < r_rs2[XLEN-2:0]);

  always_comb begin
    w_cond_true = 1'b0;
    case (r_funct3)
      3'b000:  w_cond_true = w_eq;
      3'b001:  w_cond_true = ~w_eq;
      3'b100:  w_cond_true = w_signed_lt;
      3'b101:  w_cond_true = ~w_signed_lt;
      3'b110:  w_cond_true = w_unsigned_lt;
      3'b111:  w_cond_true = ~w_unsigned_lt;
      default: w_cond_true = 1'b0;
    endcase
  end

  assign w_taken = r_is_jal | r_is_jalr | (w_is_cond & ~w_illegal & w_cond_true);

  // --------------------------------------------------------------------------
  // Target and link addresses (modulo 2^PC_W)
  // --------------------------------------------------------------------------
  assign w_branch_tgt = r_pc + r_imm[PC_W-1:0];
  assign w_jalr_sum   = r_rs1 + r_imm;
  assign w_jalr_tgt   = w_jalr_sum[PC_W-1:0] & C_CLR_BIT0;
  assign w_target     = r_is_jalr ? w_jalr_tgt : w_branch_tgt;
  assign w_link       = r_pc + C_FOUR;
  assign w_misaligned = w_taken & w_target[1];

`ifdef BRU_STATIC_PRED_EN
  assign w_pred_taken = ~r_is_jalr & (r_is_jal | (w_is_cond & r_imm[XLEN-1]));
`else
  assign w_pred_taken = 1'b0;
`endif

  // Decide whether fetch must be redirected, and to which address.
  // - jalr: fetch cannot predict it, so it always redirects unless misaligned.
  // - illegal branch: never redirects.
  // - otherwise: redirect only when the outcome differs from the prediction.
  //     * taken but predicted not-taken  -> go to the target.
  //     * not-taken but predicted taken  -> return to the fall-through pc+4.
  always_comb begin
    w_need_redir = 1'b0;
    w_redir_tgt  = w_target;
    if (r_is_jalr) begin
      w_need_redir = ~w_misaligned;
    end else if (w_illegal) begin
      w_need_redir = 1'b0;
    end else if (w_taken != w_pred_taken) begin
      if (w_taken) begin
        w_need_redir = ~w_misaligned;
      end else begin
        w_need_redir = 1'b1;
        w_redir_tgt  = w_link;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Next state and outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt   = r_state;
    o_ready       = 1'b0;
    o_res_valid   = 1'b0;
    o_taken       = 1'b0;
    o_link        = '0;
    o_illegal     = 1'b0;
    o_misaligned  = 1'b0;
    o_redir_valid = 1'b0;
    o_redir_pc    = '0;
    o_flush       = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_ready = 1'b1;
        if (i_valid) begin
          w_state_nxt = S_EVAL;
        end
      end
      S_EVAL: begin
        o_res_valid  = 1'b1;
        o_taken      = w_taken;
        o_link       = w_link;
        o_illegal    = w_illegal;
        o_misaligned = w_misaligned;
        w_state_nxt  = w_need_redir ? S_REDIRECT : S_IDLE;
      end
      S_REDIRECT: begin
        o_redir_valid = 1'b1;
        o_redir_pc    = r_redir_pc;
        if (i_redir_ready) begin
          o_flush     = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_resolve_unit
// Purpose  : Self-checking bench for branch_resolve_unit.
//            Stimulus comes from three sources:
//              - a directed vector table,
//              - hand-written sequences for reset during a pending redirect,
//              - random transactions checked against a reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_branch_resolve_unit;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_valid;
  logic        o_ready;
  logic [2:0]  i_funct3;
  logic        i_is_jal;
  logic        i_is_jalr;
  logic [31:0] i_rs1;
  logic [31:0] i_rs2;
  logic [31:0] i_imm;
  logic [31:0] i_pc;
  logic        o_res_valid;
  logic        o_taken;
  logic [31:0] o_link;
  logic        o_illegal;
  logic        o_misaligned;
  logic        o_redir_valid;
  logic        i_redir_ready;
  logic [31:0] o_redir_pc;
  logic        o_flush;

  int n_cmp = 0;
  int n_bad = 0;

  branch_resolve_unit #(.XLEN(32), .PC_W(32)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_funct3(i_funct3), .i_is_jal(i_is_jal), .i_is_jalr(i_is_jalr),
    .i_rs1(i_rs1), .i_rs2(i_rs2), .i_imm(i_imm), .i_pc(i_pc),
    .o_res_valid(o_res_valid), .o_taken(o_taken), .o_link(o_link),
    .o_illegal(o_illegal), .o_misaligned(o_misaligned),
    .o_redir_valid(o_redir_valid), .i_redir_ready(i_redir_ready),
    .o_redir_pc(o_redir_pc), .o_flush(o_flush)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [2:0]  f3;
    logic        jal;
    logic        jalr;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic [31:0] pc;
    int          dly;
    logic        taken;
    logic        illegal;
    logic        misal;
    logic        redir;
    logic [31:0] rpc;
  } vec_t;

  typedef struct {
    logic        taken;
    logic        illegal;
    logic        misal;
    logic        redir;
    logic [31:0] rpc;
  } exp_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Architectural reference: RV32I rules applied directly to the operands.
  function automatic exp_t ref_model(input logic [2:0] f3, input logic jal, input logic jalr,
                                     input logic [31:0] rs1, input logic [31:0] rs2,
                                     input logic [31:0] imm, input logic [31:0] pc);
    exp_t        e;
    logic        cond;
    logic        res;
    logic        pred;
    logic [31:0] tgt;
    cond = !jal && !jalr;
    res  = 1'b0;
    case (f3)
      3'd0: res = (rs1 == rs2);
      3'd1: res = (rs1 != rs2);
      3'd4: res = ($signed(rs1) <  $signed(rs2));
      3'd5: res = ($signed(rs1) >= $signed(rs2));
      3'd6: res = (rs1 <  rs2);
      3'd7: res = (rs1 >= rs2);
      default: res = 1'b0;
    endcase
    e.illegal = cond && (f3 == 3'd2 || f3 == 3'd3);
    e.taken   = jal || jalr || (cond && !e.illegal && res);
    tgt       = jalr ? ((rs1 + imm) & 32'hFFFF_FFFE) : (pc + imm);
    e.misal   = e.taken && tgt[1];
`ifdef BRU_STATIC_PRED_EN
    pred = !jalr && (jal || (cond && imm[31]));
`else
    pred = 1'b0;
`endif
    e.redir = 1'b0;
    e.rpc   = tgt;
    if (jalr) begin
      e.redir = !e.misal;
    end else if (!e.illegal && (e.taken != pred)) begin
      if (e.taken) begin
        e.redir = !e.misal;
      end else begin
        e.redir = 1'b1;
        e.rpc   = pc + 32'd4;
      end
    end
    return e;
  endfunction

  // One full transaction.
  // Called from IDLE at posedge+1; returns in IDLE at posedge+1.
  task automatic run_txn(input string tag, input vec_t v);
    bit done;
    chk({tag, ":ready_idle"}, {31'd0, o_ready}, 32'd1);
    i_funct3      = v.f3;
    i_is_jal      = v.jal;
    i_is_jalr     = v.jalr;
    i_rs1         = v.rs1;
    i_rs2         = v.rs2;
    i_imm         = v.imm;
    i_pc          = v.pc;
    i_valid       = 1'b1;
    i_redir_ready = 1'b0;
    tick();
    // EVAL: result strobe exactly one cycle after accept
    i_valid       = 1'b0;
    i_redir_ready = (v.dly == 0);
    #1;
    chk({tag, ":res_valid"}, {31'd0, o_res_valid}, 32'd1);
    chk({tag, ":taken"},     {31'd0, o_taken},     {31'd0, v.taken});
    chk({tag, ":illegal"},   {31'd0, o_illegal},   {31'd0, v.illegal});
    chk({tag, ":misal"},     {31'd0, o_misaligned}, {31'd0, v.misal});
    chk({tag, ":link"},      o_link,               v.pc + 32'd4);
    chk({tag, ":ready_eval"}, {31'd0, o_ready},    32'd0);
    tick();
    if (v.redir) begin
      done = 1'b0;
      for (int k = 0; k < 20 && !done; k++) begin
        i_redir_ready = (k >= v.dly);
        // decode tries to push something new while the redirect is pending
        i_valid = !i_redir_ready;
        i_pc    = $urandom;
        #1;
        chk({tag, ":redir_valid"}, {31'd0, o_redir_valid}, 32'd1);
        chk({tag, ":redir_pc"},    o_redir_pc,              v.rpc);
        chk({tag, ":ready_redir"}, {31'd0, o_ready},        32'd0);
        chk({tag, ":flush"},       {31'd0, o_flush},        {31'd0, i_redir_ready});
        if (i_redir_ready) done = 1'b1;
        tick();
      end
      i_valid       = 1'b0;
      i_redir_ready = 1'b0;
      #1;
    end else begin
      i_redir_ready = 1'b0;
      #1;
    end
    chk({tag, ":redir_drop"}, {31'd0, o_redir_valid}, 32'd0);
    chk({tag, ":flush_idle"}, {31'd0, o_flush},       32'd0);
    chk({tag, ":res_once"},   {31'd0, o_res_valid},   32'd0);
    chk({tag, ":ready_back"}, {31'd0, o_ready},       32'd1);
  endtask

  vec_t tbl[12];
  vec_t rv;
  exp_t m;

  initial begin
    //               f3    jal   jalr  rs1            rs2            imm            pc             dly tk  il  mis rd  rpc
    tbl[0]  = '{3'd4, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0020, 32'h0000_0100, 1, 1, 0, 0, 1, 32'h0000_0120};
    tbl[1]  = '{3'd6, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0020, 32'h0000_0100, 0, 0, 0, 0, 0, 32'h0};
    tbl[2]  = '{3'd0, 1'b0, 1'b1, 32'h0000_1003, 32'h0,         32'h0000_0004, 32'h0000_0200, 0, 1, 0, 1, 0, 32'h0};
    tbl[3]  = '{3'd0, 1'b0, 1'b0, 32'h0000_0005, 32'h0000_0005, 32'h0000_0010, 32'h0000_0040, 3, 1, 0, 0, 1, 32'h0000_0050};
    tbl[4]  = '{3'd2, 1'b0, 1'b0, 32'h0,         32'h0,         32'h0000_0008, 32'h0000_0080, 0, 0, 1, 0, 0, 32'h0};
    tbl[5]  = '{3'd1, 1'b0, 1'b0, 32'h0000_0005, 32'h0000_0005, 32'h0000_0008, 32'h0000_0300, 0, 0, 0, 0, 0, 32'h0};
    tbl[6]  = '{3'd5, 1'b0, 1'b0, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0040, 32'h0000_0400, 0, 0, 0, 0, 0, 32'h0};
    tbl[7]  = '{3'd7, 1'b0, 1'b0, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0040, 32'h0000_0400, 0, 1, 0, 0, 1, 32'h0000_0440};
    tbl[8]  = '{3'd0, 1'b0, 1'b0, 32'h0000_0007, 32'h0000_0007, 32'h0000_0020, 32'hFFFF_FFF0, 2, 1, 0, 0, 1, 32'h0000_0010};
    tbl[9]  = '{3'd1, 1'b0, 1'b0, 32'h0000_0001, 32'h0000_0002, 32'h0000_0006, 32'h0000_0100, 0, 1, 0, 1, 0, 32'h0};
    tbl[10] = '{3'd0, 1'b1, 1'b1, 32'h0000_2000, 32'h0,         32'h0000_0010, 32'h0000_0500, 1, 1, 0, 0, 1, 32'h0000_2010};
    tbl[11] = '{3'd3, 1'b0, 1'b0, 32'h0000_0001, 32'h0000_0001, 32'h0000_0010, 32'h0000_0600, 0, 0, 1, 0, 0, 32'h0};

    i_rst = 1'b1; i_valid = 1'b0; i_funct3 = '0; i_is_jal = 1'b0; i_is_jalr = 1'b0;
    i_rs1 = '0; i_rs2 = '0; i_imm = '0; i_pc = '0; i_redir_ready = 1'b0;
    tick();
    tick();
    chk("rst:ready",       {31'd0, o_ready},       32'd1);
    chk("rst:res_valid",   {31'd0, o_res_valid},   32'd0);
    chk("rst:redir_valid", {31'd0, o_redir_valid}, 32'd0);
    chk("rst:flush",       {31'd0, o_flush},       32'd0);
    chk("rst:link",        o_link,                 32'd0);
    chk("rst:redir_pc",    o_redir_pc,             32'd0);
    i_rst = 1'b0;
    tick();

    for (int i = 0; i < 12; i++) begin
      run_txn($sformatf("tbl%0d", i), tbl[i]);
    end

    // Reset while a redirect is pending: outputs clear at once, no flush.
    i_funct3 = 3'd0; i_is_jal = 1'b0; i_is_jalr = 1'b0;
    i_rs1 = 32'd9; i_rs2 = 32'd9; i_imm = 32'h10; i_pc = 32'h700;
    i_valid = 1'b1; i_redir_ready = 1'b0;
    tick();
    i_valid = 1'b0;
    tick();
    chk("arst:pending", {31'd0, o_redir_valid}, 32'd1);
    #2;
    i_rst = 1'b1;
    #1;
    chk("arst:redir_valid", {31'd0, o_redir_valid}, 32'd0);
    chk("arst:flush",       {31'd0, o_flush},       32'd0);
    chk("arst:ready",       {31'd0, o_ready},       32'd1);
    chk("arst:redir_pc",    o_redir_pc,             32'd0);
    tick();
    i_rst = 1'b0;
    i_redir_ready = 1'b1;
    tick();
    #1;
    chk("arst:after_flush", {31'd0, o_flush},       32'd0);
    chk("arst:after_redir", {31'd0, o_redir_valid}, 32'd0);
    i_redir_ready = 1'b0;

    // Reset during EVAL: result strobe disappears immediately.
    i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    i_rst = 1'b1;
    #1;
    chk("erst:res_valid", {31'd0, o_res_valid}, 32'd0);
    chk("erst:ready",     {31'd0, o_ready},     32'd1);
    tick();
    i_rst = 1'b0;
    tick();

    // Random transactions against the reference model.
    for (int i = 0; i < 300; i++) begin
      int sel;
      sel     = $urandom_range(0, 9);
      rv.jalr = (sel == 0) || (sel == 2);
      rv.jal  = (sel == 1) || (sel == 2);
      rv.f3   = 3'($urandom_range(0, 7));
      rv.rs1  = $urandom;
      case ($urandom_range(0, 3))
        0:       rv.rs2 = rv.rs1;
        1:       rv.rs2 = rv.rs1 ^ 32'h8000_0000;
        2:       rv.rs2 = rv.rs1 + 32'd1;
        default: rv.rs2 = $urandom;
      endcase
      rv.imm = 32'(int'($urandom_range(0, 4095)) - 2048) & 32'hFFFF_FFFE;
      rv.pc  = ($urandom_range(0, 7) == 0) ? (32'hFFFF_F000 | ($urandom & 32'hFFC))
                                            : ($urandom & 32'hFFFF_FFFC);
      rv.dly = $urandom_range(0, 3);
      m = ref_model(rv.f3, rv.jal, rv.jalr, rv.rs1, rv.rs2, rv.imm, rv.pc);
      rv.taken   = m.taken;
      rv.illegal = m.illegal;
      rv.misal   = m.misal;
      rv.redir   = m.redir;
      rv.rpc     = m.rpc;
      run_txn("rnd", rv);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
